// File: rtl/rocfifo_packer_pkg.sv
// rocfifo_packer_pkg: shared ROCFIFO header layout and packer FSM state encoding
package rocfifo_packer_pkg;

    localparam int DIGI_BITS       = 32;
    localparam int SPILL_TAG_BITS  = 20;
    localparam int EVENT_SIZE_BITS = 12;
    localparam int SIZE_MSB        = 31;
    localparam int SIZE_LSB        = 20;
    localparam int TAG_MSB         = 19;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HEADER, S_DRAIN} state_t;

    function automatic logic [DIGI_BITS-1:0] mk_header(input logic [EVENT_SIZE_BITS-1:0] size,
                                                       input logic [SPILL_TAG_BITS-1:0] tag);
        logic [DIGI_BITS-1:0] h;
        h = '0;
        h[SIZE_MSB:SIZE_LSB] = size;
        h[TAG_MSB:0] = tag;
        return h;
    endfunction

endpackage

// File: rtl/rocfifo_packer_buf.sv
// rocfifo_packer_buf: simple dual-port staging RAM, one write port, one registered read port
//   i_clk    clock
//   i_we     write enable, i_waddr/i_wdata write address/data
//   i_raddr  read address, o_rdata read data one cycle later
module rocfifo_packer_buf #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/rocfifo_packer.sv
// rocfifo_packer: buffers one event window of digi words, then writes {size,tag} header + payload to the ROCFIFO
//   serdesclk, reset_serdesclk (async, active-high)
//   ew_start/ew_tag_in open an EW, ew_end closes it, hit_valid/hit_data payload words
//   rocfifo_afull stalls writes; rocfifo_we/rocfifo_data drive the ROCFIFO
//   busy (not idle), ew_ovfl (sticky truncation), proto_err (1-cycle pulse), drop_cnt (dropped hits)
//   Build option ROCPACK_DROPCNT_EN: implements drop_cnt; otherwise drop_cnt is tied to 0.
module rocfifo_packer
    import rocfifo_packer_pkg::*;
#(
    parameter int          MAX_WORDS = 4094,
    parameter logic [31:0] PAD_WORD  = 32'h0,
    parameter int          BUF_AW    = 12
) (
    input  logic                      serdesclk,
    input  logic                      reset_serdesclk,
    input  logic                      ew_start,
    input  logic [SPILL_TAG_BITS-1:0] ew_tag_in,
    input  logic                      ew_end,
    input  logic                      hit_valid,
    input  logic [DIGI_BITS-1:0]      hit_data,
    input  logic                      rocfifo_afull,
    output logic                      rocfifo_we,
    output logic [DIGI_BITS-1:0]      rocfifo_data,
    output logic                      busy,
    output logic                      ew_ovfl,
    output logic                      proto_err,
    output logic [15:0]               drop_cnt
);

    localparam logic [BUF_AW:0] MAXW = (BUF_AW+1)'(MAX_WORDS);

    state_t                    r_state, w_next;
    logic [SPILL_TAG_BITS-1:0] r_tag;
    logic [BUF_AW:0]           r_wr_cnt;
    logic [BUF_AW-1:0]         r_rd_ptr;
    logic                      r_hdr_rdy;
    logic                      r_ovfl;
    logic                      r_perr;
    logic [DIGI_BITS-1:0]      w_rd_data;
    logic [BUF_AW-1:0]         w_rd_addr;
    logic                      w_open, w_take, w_pad, w_hdr_we, w_drn_we, w_last;

    assign w_open   = (r_state == S_IDLE) && ew_start;
    assign w_take   = (r_state == S_COLLECT) && hit_valid && (r_wr_cnt < MAXW);
    // First HEADER cycle rounds an odd count up with the pad word; the header may only go out afterwards.
    assign w_pad    = (r_state == S_HEADER) && !r_hdr_rdy && r_wr_cnt[0];
    assign w_hdr_we = (r_state == S_HEADER) && r_hdr_rdy && !rocfifo_afull;
    assign w_drn_we = (r_state == S_DRAIN) && !rocfifo_afull;
    assign w_last   = {1'b0, r_rd_ptr} == r_wr_cnt - 1'b1;
    // Look ahead one address on each write so read data always holds the word at r_rd_ptr.
    assign w_rd_addr = w_drn_we ? r_rd_ptr + 1'b1 : r_rd_ptr;

    rocfifo_packer_buf #(.AW(BUF_AW), .DW(DIGI_BITS)) u_buf (
        .i_clk   (serdesclk),
        .i_we    (w_take || w_pad),
        .i_waddr (r_wr_cnt[BUF_AW-1:0]),
        .i_wdata (w_pad ? PAD_WORD : hit_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge serdesclk or posedge reset_serdesclk) begin
        if (reset_serdesclk) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    w_next = ew_start ? S_COLLECT : S_IDLE;
            S_COLLECT: w_next = ew_end ? S_HEADER : S_COLLECT;
            S_HEADER:  w_next = !w_hdr_we ? S_HEADER : (r_wr_cnt == '0) ? S_IDLE : S_DRAIN;
            S_DRAIN:   w_next = (w_drn_we && w_last) ? S_IDLE : S_DRAIN;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rocfifo_we   = w_hdr_we || w_drn_we;
        rocfifo_data = w_hdr_we ? mk_header(EVENT_SIZE_BITS'(r_wr_cnt), r_tag) : w_drn_we ? w_rd_data : '0;
        busy         = r_state != S_IDLE;
    end

    always_ff @(posedge serdesclk or posedge reset_serdesclk) begin
        if (reset_serdesclk) begin
            r_tag     <= '0;
            r_wr_cnt  <= '0;
            r_rd_ptr  <= '0;
            r_hdr_rdy <= 1'b0;
            r_ovfl    <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_tag     <= w_open ? ew_tag_in : r_tag;
            r_wr_cnt  <= w_open ? '0 : (w_take || w_pad) ? r_wr_cnt + 1'b1 : r_wr_cnt;
            r_rd_ptr  <= w_open ? '0 : w_rd_addr;
            r_hdr_rdy <= r_state == S_HEADER;
            r_ovfl    <= w_open ? 1'b0 : (r_state == S_COLLECT && hit_valid && !w_take) ? 1'b1 : r_ovfl;
            r_perr    <= (r_state == S_IDLE) ? (ew_end && !ew_start) : ew_start;
        end
    end

    assign ew_ovfl   = r_ovfl;
    assign proto_err = r_perr;

`ifdef ROCPACK_DROPCNT_EN
    logic [15:0] r_drop;
    always_ff @(posedge serdesclk or posedge reset_serdesclk) begin
        if (reset_serdesclk) r_drop <= '0;
        else r_drop <= (hit_valid && !w_take && r_drop != 16'hFFFF) ? r_drop + 1'b1 : r_drop;
    end
    assign drop_cnt = r_drop;
`else
    assign drop_cnt = '0;
`endif

endmodule
